// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the accumulator-style CPU: bus widths, instruction
// field positions, the opcode and FSM state enums, and an opcode decode helper.
// No ports (package).
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  // Instruction fields: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm8/address
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_JMP  = 4'h4,
    OP_JZ   = 4'h5,
    OP_XOR  = 4'h6,
    OP_ADDI = 4'h7,
    OP_LDI  = 4'h8,
    OP_LD   = 4'h9,
    OP_ST   = 4'hA,
    OP_MOV  = 4'hB,
    OP_SHL  = 4'hC,
    OP_SHR  = 4'hD,
    OP_NOP  = 4'hE,
    OP_HLT  = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  function automatic opcode_e get_opcode(input logic [DATA_W-1:0] instr);
    return opcode_e'(instr[OPC_MSB:OPC_LSB]);
  endfunction

endpackage

// File: rtl/cpu_ram.sv
// cpu_ram
// 256x16 unified program/data memory. Combinational read, synchronous write,
// no reset so contents survive a CPU reset. The storage array is named RAM so
// programs can be loaded hierarchically.
// Ports:
//   clk    in   clock, write happens on the rising edge
//   we     in   write enable
//   addr   in   [ADDR_W-1:0] word address shared by read and write
//   wdata  in   [DATA_W-1:0] write data
//   rdata  out  [DATA_W-1:0] combinational read data, RAM[addr]
module cpu_ram
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] RAM [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      RAM[addr] <= wdata;
    end
  end

  assign rdata = RAM[addr];

endmodule

// File: rtl/cpu_core.sv
// cpu_core
// Minimal multi-cycle 16-bit accumulator-style CPU. Every instruction takes
// exactly two clocks: FETCH loads the instruction register and bumps the PC,
// EXEC performs the operation. HLT parks the FSM in HALT until reset.
// Register file (R0..R3), Z/C flags and ALU live here; memory is cpu_ram.
// Ports:
//   clk    in  single clock, all state updates on the rising edge
//   reset  in  asynchronous, active-low reset (0 = in reset)
module cpu_core
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic reset
);

  logic [ADDR_W-1:0] pc_address;
  logic [ADDR_W-1:0] pc_address_d;
  logic [DATA_W-1:0] current_instruction;
  logic [DATA_W-1:0] current_instruction_d;
  logic [DATA_W-1:0] regs_q [4];
  logic [DATA_W-1:0] regs_d [4];
  logic              z_q;
  logic              z_d;
  logic              c_q;
  logic              c_d;
  state_e            state_q;
  state_e            state_d;

  logic [DATA_W-1:0] RAM_read;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;

  opcode_e           opcode;
  logic [1:0]        rd_idx;
  logic [1:0]        rs_idx;
  logic [7:0]        imm8;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;
  logic              is_mem_op;

  logic              rd_we;
  logic [DATA_W-1:0] rd_wdata;
  logic [DATA_W:0]   sum;

  assign opcode = get_opcode(current_instruction);
  assign rd_idx = current_instruction[RD_MSB:RD_LSB];
  assign rs_idx = current_instruction[RS_MSB:RS_LSB];
  assign imm8   = current_instruction[IMM_MSB:IMM_LSB];
  assign rd_val = regs_q[rd_idx];
  assign rs_val = regs_q[rs_idx];

  // Memory is addressed by the PC except while a LD/ST is executing.
  assign is_mem_op = (state_q == ST_EXEC) && ((opcode == OP_LD) || (opcode == OP_ST));
  assign ram_addr  = is_mem_op ? imm8 : pc_address;
  assign ram_we    = (state_q == ST_EXEC) && (opcode == OP_ST);

  cpu_ram ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (rd_val),
    .rdata (RAM_read)
  );

  // Next-state, datapath and flag computation. Register writes are funnelled
  // through rd_we/rd_wdata so only the addressed register changes.
  always_comb begin
    pc_address_d          = pc_address;
    current_instruction_d = current_instruction;
    z_d                   = z_q;
    c_d                   = c_q;
    state_d               = state_q;
    rd_we                 = 1'b0;
    rd_wdata              = rd_val;
    sum                   = '0;

    case (state_q)
      ST_FETCH: begin
        current_instruction_d = RAM_read;
        pc_address_d          = pc_address + 8'd1;
        state_d               = ST_EXEC;
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        case (opcode)
          OP_ADD: begin
            sum      = {1'b0, rd_val} + {1'b0, rs_val};
            rd_we    = 1'b1;
            rd_wdata = sum[DATA_W-1:0];
            c_d      = sum[DATA_W];
            z_d      = (sum[DATA_W-1:0] == '0);
          end
          OP_SUB: begin
            // Bit 16 of the 17-bit difference is the borrow.
            sum      = {1'b0, rd_val} - {1'b0, rs_val};
            rd_we    = 1'b1;
            rd_wdata = sum[DATA_W-1:0];
            c_d      = sum[DATA_W];
            z_d      = (sum[DATA_W-1:0] == '0);
          end
          OP_AND: begin
            rd_we    = 1'b1;
            rd_wdata = rd_val & rs_val;
            z_d      = ((rd_val & rs_val) == '0);
          end
          OP_OR: begin
            rd_we    = 1'b1;
            rd_wdata = rd_val | rs_val;
            z_d      = ((rd_val | rs_val) == '0);
          end
          OP_XOR: begin
            rd_we    = 1'b1;
            rd_wdata = rd_val ^ rs_val;
            z_d      = ((rd_val ^ rs_val) == '0);
          end
          OP_JMP: begin
            pc_address_d = imm8;
          end
          OP_JZ: begin
            if (z_q) begin
              pc_address_d = imm8;
            end
          end
          OP_ADDI: begin
            sum      = {1'b0, rd_val} + {9'd0, imm8};
            rd_we    = 1'b1;
            rd_wdata = sum[DATA_W-1:0];
            c_d      = sum[DATA_W];
            z_d      = (sum[DATA_W-1:0] == '0);
          end
          OP_LDI: begin
            rd_we    = 1'b1;
            rd_wdata = {8'd0, imm8};
          end
          OP_LD: begin
            rd_we    = 1'b1;
            rd_wdata = RAM_read;
          end
          OP_MOV: begin
            rd_we    = 1'b1;
            rd_wdata = rs_val;
          end
          OP_SHL: begin
            rd_we    = 1'b1;
            rd_wdata = {rd_val[DATA_W-2:0], 1'b0};
            c_d      = rd_val[DATA_W-1];
            z_d      = (rd_val[DATA_W-2:0] == '0);
          end
          OP_SHR: begin
            rd_we    = 1'b1;
            rd_wdata = {1'b0, rd_val[DATA_W-1:1]};
            c_d      = rd_val[0];
            z_d      = (rd_val[DATA_W-1:1] == '0);
          end
          OP_HLT: begin
            state_d = ST_HALT;
          end
          default: begin
            // ST is handled by the RAM write port; NOP does nothing.
          end
        endcase
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      regs_d[i] = (rd_we && (rd_idx == 2'(i))) ? rd_wdata : regs_q[i];
    end
  end

  // Asynchronous reset aborts any instruction in flight; since ram_we is
  // derived from state_q, a reset during EXEC of ST also suppresses the write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_address          <= '0;
      current_instruction <= '0;
      z_q                 <= 1'b0;
      c_q                 <= 1'b0;
      state_q             <= ST_FETCH;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      pc_address          <= pc_address_d;
      current_instruction <= current_instruction_d;
      z_q                 <= z_d;
      c_q                 <= c_d;
      state_q             <= state_d;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core
// Scoreboard bench for cpu_core. Each directed program pushes its expected
// fetch-address trace and final halted state into a queue; a monitor pops an
// entry every time the core presents a FETCH cycle or first enters HALT.
// No ports (top-level bench).
module tb_cpu_core;
  import cpu_pkg::*;

  typedef struct {
    logic        is_halt;
    logic [7:0]  pc;
    logic [15:0] r0;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [15:0] r3;
    logic        z;
    logic        c;
  } exp_t;

  logic clk;
  logic reset;

  exp_t sb[$];
  int   vectors_applied = 0;
  int   miscompares     = 0;
  logic halt_seen       = 1'b0;

  cpu_core dut (
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic expect_fetch(input logic [7:0] pc);
    exp_t e;
    e.is_halt = 1'b0;
    e.pc = pc;
    e.r0 = '0; e.r1 = '0; e.r2 = '0; e.r3 = '0;
    e.z = 1'b0; e.c = 1'b0;
    sb.push_back(e);
  endtask

  task automatic expect_halt(input logic [7:0] pc, input logic [15:0] r0, input logic [15:0] r1,
                             input logic [15:0] r2, input logic [15:0] r3, input logic z, input logic c);
    exp_t e;
    e.is_halt = 1'b1;
    e.pc = pc;
    e.r0 = r0; e.r1 = r1; e.r2 = r2; e.r3 = r3;
    e.z = z; e.c = c;
    sb.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from state updates.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      halt_seen = 1'b0;
    end else if (dut.state_q == ST_FETCH) begin
      if (sb.size() == 0) begin
        check_output("unexpected_fetch", {24'd0, dut.pc_address}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check_output("fetch_kind", 32'd0, {31'd0, e.is_halt});
        check_output("fetch_pc", {24'd0, dut.pc_address}, {24'd0, e.pc});
      end
    end else if (dut.state_q == ST_HALT && !halt_seen) begin
      halt_seen = 1'b1;
      if (sb.size() == 0) begin
        check_output("unexpected_halt", {24'd0, dut.pc_address}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check_output("halt_kind", 32'd1, {31'd0, e.is_halt});
        check_output("halt_pc", {24'd0, dut.pc_address}, {24'd0, e.pc});
        check_output("halt_r0", {16'd0, dut.regs_q[0]}, {16'd0, e.r0});
        check_output("halt_r1", {16'd0, dut.regs_q[1]}, {16'd0, e.r1});
        check_output("halt_r2", {16'd0, dut.regs_q[2]}, {16'd0, e.r2});
        check_output("halt_r3", {16'd0, dut.regs_q[3]}, {16'd0, e.r3});
        check_output("halt_z", {31'd0, dut.z_q}, {31'd0, e.z});
        check_output("halt_c", {31'd0, dut.c_q}, {31'd0, e.c});
      end
    end
  end

  task automatic clear_ram();
    for (int i = 0; i < 256; i++) begin
      dut.ram.RAM[i] = 16'h0000;
    end
  endtask

  // Put the core in reset and start a fresh program image.
  task automatic begin_test();
    reset = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    clear_ram();
  endtask

  // Release just after a rising edge so the monitor sees the first FETCH.
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic run_until_halt(input int max_cycles);
    int n = 0;
    while (dut.state_q != ST_HALT && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (dut.state_q != ST_HALT) begin
      check_output("halt_timeout", {30'd0, dut.state_q}, {30'd0, ST_HALT});
    end
    @(negedge clk);
    #1;
    check_output("sb_drained", sb.size(), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b0;

    // Test 1: reset state; RAM preload survives reset.
    clear_ram();
    dut.ram.RAM[8'h50] = 16'hBEEF;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_pc", {24'd0, dut.pc_address}, 32'd0);
    check_output("rst_ir", {16'd0, dut.current_instruction}, 32'd0);
    check_output("rst_r0", {16'd0, dut.regs_q[0]}, 32'd0);
    check_output("rst_r1", {16'd0, dut.regs_q[1]}, 32'd0);
    check_output("rst_r2", {16'd0, dut.regs_q[2]}, 32'd0);
    check_output("rst_r3", {16'd0, dut.regs_q[3]}, 32'd0);
    check_output("rst_state", {30'd0, dut.state_q}, {30'd0, ST_FETCH});
    check_output("rst_ram_keep", {16'd0, dut.ram.RAM[8'h50]}, 32'h0000_BEEF);

    // Test 2: LDI/LDI/ADD/HLT; PC frozen after halt.
    begin_test();
    dut.ram.RAM[0] = 16'h8005;
    dut.ram.RAM[1] = 16'h8403;
    dut.ram.RAM[2] = 16'h0100;
    dut.ram.RAM[3] = 16'hF000;
    for (int i = 0; i < 4; i++) expect_fetch(8'(i));
    expect_halt(8'h04, 16'h0008, 16'h0003, 16'h0000, 16'h0000, 1'b0, 1'b0);
    apply_stimulus();
    run_until_halt(20);
    repeat (4) @(posedge clk);
    #1;
    check_output("t2_pc_frozen", {24'd0, dut.pc_address}, 32'd4);

    // Test 3: JMP skips address 2.
    begin_test();
    dut.ram.RAM[0] = 16'h0102;
    dut.ram.RAM[1] = 16'h4103;
    dut.ram.RAM[2] = 16'h8C77;
    dut.ram.RAM[3] = 16'h8004;
    dut.ram.RAM[4] = 16'hF000;
    expect_fetch(8'h00);
    expect_fetch(8'h01);
    expect_fetch(8'h03);
    expect_fetch(8'h04);
    expect_halt(8'h05, 16'h0004, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
    apply_stimulus();
    run_until_halt(20);

    // Test 4: SHL x8, ADDI, SUB to zero, taken JZ.
    begin_test();
    dut.ram.RAM[0] = 16'h80FF;
    for (int i = 1; i <= 8; i++) dut.ram.RAM[i] = 16'hC000;
    dut.ram.RAM[9]  = 16'h7001;
    dut.ram.RAM[10] = 16'h8401;
    dut.ram.RAM[11] = 16'h1500;
    dut.ram.RAM[12] = 16'h5020;
    dut.ram.RAM[8'h20] = 16'hF000;
    for (int i = 0; i <= 12; i++) expect_fetch(8'(i));
    expect_fetch(8'h20);
    expect_halt(8'h21, 16'hFF01, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
    apply_stimulus();
    run_until_halt(60);

    // Test 5: ST/LD round trip, then fetch at 0xFF wraps the PC to 0x00.
    begin_test();
    dut.ram.RAM[0] = 16'h88AB;
    dut.ram.RAM[1] = 16'hA880;
    dut.ram.RAM[2] = 16'h9C80;
    dut.ram.RAM[3] = 16'h40FF;
    dut.ram.RAM[8'hFF] = 16'hF000;
    for (int i = 0; i < 4; i++) expect_fetch(8'(i));
    expect_fetch(8'hFF);
    expect_halt(8'h00, 16'h0000, 16'h0000, 16'h00AB, 16'h00AB, 1'b0, 1'b0);
    apply_stimulus();
    run_until_halt(30);
    check_output("t5_ram80", {16'd0, dut.ram.RAM[8'h80]}, 32'h0000_00AB);

    // Test 7: logic ops, SHR, MOV, SUB borrow, ADD carry, untaken JZ, ADDI.
    begin_test();
    dut.ram.RAM[0]  = 16'h80FF;
    dut.ram.RAM[1]  = 16'h8C0F;
    dut.ram.RAM[2]  = 16'h6300;
    dut.ram.RAM[3]  = 16'h3300;
    dut.ram.RAM[4]  = 16'h2300;
    dut.ram.RAM[5]  = 16'hD000;
    dut.ram.RAM[6]  = 16'hB800;
    dut.ram.RAM[7]  = 16'h1B00;
    dut.ram.RAM[8]  = 16'h0A00;
    dut.ram.RAM[9]  = 16'h5030;
    dut.ram.RAM[10] = 16'h7C01;
    dut.ram.RAM[11] = 16'hF000;
    for (int i = 0; i < 12; i++) expect_fetch(8'(i));
    expect_halt(8'h0C, 16'h0007, 16'h0000, 16'hFFF0, 16'h0010, 1'b0, 1'b0);
    apply_stimulus();
    run_until_halt(40);

    // Test 6: reset during EXEC of ST aborts the write; refetch from 0.
    begin_test();
    dut.ram.RAM[0] = 16'h8855;
    dut.ram.RAM[1] = 16'hA890;
    dut.ram.RAM[8'h90] = 16'h1234;
    expect_fetch(8'h00);
    expect_fetch(8'h01);
    apply_stimulus();
    n = 0;
    while (!(dut.state_q == ST_EXEC && dut.current_instruction[15:12] == 4'hA) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("t6_in_st_exec", {16'd0, dut.current_instruction}, 32'h0000_A890);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_output("t6_ram_kept", {16'd0, dut.ram.RAM[8'h90]}, 32'h0000_1234);
    check_output("t6_pc", {24'd0, dut.pc_address}, 32'd0);
    check_output("t6_r2", {16'd0, dut.regs_q[2]}, 32'd0);
    check_output("t6_sb_drained", sb.size(), 32'd0);
    dut.ram.RAM[0] = 16'hF000;
    expect_fetch(8'h00);
    expect_halt(8'h01, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    apply_stimulus();
    run_until_halt(10);
    check_output("t6_ram_final", {16'd0, dut.ram.RAM[8'h90]}, 32'h0000_1234);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
